// File: rtl/i_decode.sv
// rtl/i_decode.sv - decode stage: control decode, 32x32 register file with write-through, ID/EX latch
module i_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic        EX_MEM_PCSrc,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_writereg,
    input  logic [31:0] MEM_WB_writedata,
    output logic [1:0]  ID_EX_wb,
    output logic [2:0]  ID_EX_m,
    output logic [3:0]  ID_EX_ex,
    output logic [31:0] ID_EX_npc,
    output logic [31:0] ID_EX_readdat1,
    output logic [31:0] ID_EX_readdat2,
    output logic [31:0] ID_EX_sign_ext,
    output logic [4:0]  ID_EX_instr_2016,
    output logic [4:0]  ID_EX_instr_1511
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wr_en;
    logic [1:0]  wb_next;
    logic [2:0]  m_next;
    logic [3:0]  ex_next;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] sign_ext;

    assign opcode   = IF_ID_instr[31:26];
    assign rs       = IF_ID_instr[25:21];
    assign rt       = IF_ID_instr[20:16];
    assign sign_ext = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
    assign wr_en    = MEM_WB_RegWrite && (MEM_WB_writereg != 5'd0);

    always_comb begin
        wb_next = 2'b00;
        m_next  = 3'b000;
        ex_next = 4'b0000;
        case (opcode)
            OP_RTYPE: begin wb_next = 2'b10; m_next = 3'b000; ex_next = 4'b1100; end
            OP_LW:    begin wb_next = 2'b11; m_next = 3'b010; ex_next = 4'b0001; end
            OP_SW:    begin wb_next = 2'b00; m_next = 3'b001; ex_next = 4'b0001; end
            OP_BEQ:   begin wb_next = 2'b00; m_next = 3'b100; ex_next = 4'b0010; end
            default:  begin wb_next = 2'b00; m_next = 3'b000; ex_next = 4'b0000; end
        endcase
    end

    // A same-cycle write-back wins over the stale array contents; r0 is hardwired to zero.
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        if (rs != 5'd0)
            rs_data = (wr_en && MEM_WB_writereg == rs) ? MEM_WB_writedata : regs[rs];
        if (rt != 5'd0)
            rt_data = (wr_en && MEM_WB_writereg == rt) ? MEM_WB_writedata : regs[rt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (wr_en) begin
            regs[MEM_WB_writereg] <= MEM_WB_writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX_wb         <= 2'b00;
            ID_EX_m          <= 3'b000;
            ID_EX_ex         <= 4'b0000;
            ID_EX_npc        <= 32'd0;
            ID_EX_readdat1   <= 32'd0;
            ID_EX_readdat2   <= 32'd0;
            ID_EX_sign_ext   <= 32'd0;
            ID_EX_instr_2016 <= 5'd0;
            ID_EX_instr_1511 <= 5'd0;
        end else begin
            // A taken branch squashes only control; datapath fields still load.
            ID_EX_wb         <= EX_MEM_PCSrc ? 2'b00   : wb_next;
            ID_EX_m          <= EX_MEM_PCSrc ? 3'b000  : m_next;
            ID_EX_ex         <= EX_MEM_PCSrc ? 4'b0000 : ex_next;
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= rs_data;
            ID_EX_readdat2   <= rt_data;
            ID_EX_sign_ext   <= sign_ext;
            ID_EX_instr_2016 <= IF_ID_instr[20:16];
            ID_EX_instr_1511 <= IF_ID_instr[15:11];
        end
    end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the five-stage pipeline. Consumes the IF/ID latch outputs (`IF_ID_instr`, `IF_ID_npc`) from fetch, decodes control for the four supported opcodes, reads two operands from a 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX latch. It also accepts the write-back port from MEM/WB, and a flush from EX/MEM when a branch is taken.

## Interface
- No parameters; widths are fixed (32-bit datapath, 5-bit register index).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `IF_ID_instr` input 32: instruction from the IF/ID latch.
- `IF_ID_npc` input 32: PC+4 from the IF/ID latch.
- `EX_MEM_PCSrc` input 1: branch taken; flushes the instruction currently in decode.
- `MEM_WB_RegWrite` input 1: register-file write enable.
- `MEM_WB_writereg` input 5: write index.
- `MEM_WB_writedata` input 32: write data.
- `ID_EX_wb` output 2: {RegWrite, MemtoReg}.
- `ID_EX_m` output 3: {Branch, MemRead, MemWrite}.
- `ID_EX_ex` output 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_npc` output 32: registered `IF_ID_npc`.
- `ID_EX_readdat1` output 32: registered rs operand.
- `ID_EX_readdat2` output 32: registered rt operand.
- `ID_EX_sign_ext` output 32: registered sign-extended instr[15:0].
- `ID_EX_instr_2016` output 5: registered instr[20:16].
- `ID_EX_instr_1511` output 5: registered instr[15:11].

## Operation
- Opcode is instr[31:26]. Control words are {wb, m, ex}:
  - 0x00 (R-type): wb=2'b10, m=3'b000, ex=4'b1100.
  - 0x23 (lw): wb=2'b11, m=3'b010, ex=4'b0001.
  - 0x2B (sw): wb=2'b00, m=3'b001, ex=4'b0001.
  - 0x04 (beq): wb=2'b00, m=3'b100, ex=4'b0010.
  - Any other opcode is treated as a NOP: wb, m and ex are all zero. Datapath fields are still latched.
- Register file: 32 entries x 32 bits. rs=instr[25:21], rt=instr[20:16].
  - Reads are combinational into the ID/EX latch.
  - Writes occur on the rising edge when `MEM_WB_RegWrite`=1 and `MEM_WB_writereg`!=0.
  - Register 0 always reads 0, and writes to it are ignored.
- Write-through bypass: if a write is enabled to register r (r!=0) and the same cycle reads rs or rt == r, the latched read data is `MEM_WB_writedata`, not the old contents.
- Sign extension: `ID_EX_sign_ext` = {{16{instr[15]}}, instr[15:0]}.
- Flush: when `EX_MEM_PCSrc`=1 at the clock edge, `ID_EX_wb`, `ID_EX_m` and `ID_EX_ex` load zero. Datapath fields load normally.
- A register-file write is never suppressed by flush.

## Timing
- Latency: one cycle. Values presented on IF_ID_* before edge N appear on ID_EX_* after edge N.
- A write at edge N is visible to a read in the same cycle via bypass, and from array contents for any later read.
- Reset (async, takes effect immediately, independent of `clk`):
  - Every ID_EX_* output is 0.
  - All 32 registers are 0.
- Reset asserted mid-operation discards the in-flight latch contents and any write in that cycle.
- First update after reset deassertion is at the next rising edge.
- Flush and write-back in the same cycle: control is zeroed, and the write still commits.
- Reset has priority over flush, and flush has priority over decode.

## Test plan
- Reset: assert `rst` mid-cycle -> all ID_EX_* outputs are 0 immediately. After release, lw of r5 (array contents) reads 0.
- R-type: write r1=0x11, r2=0x22, then IF_ID_instr=0x00221820, npc=0x8 -> after one edge:
  - wb=10, m=000, ex=1100.
  - readdat1=0x11, readdat2=0x22.
  - instr_2016=2, instr_1511=3, npc=0x8.
- lw and sign extension: IF_ID_instr=0x8C22FFFC -> wb=11, m=010, ex=0001, sign_ext=0xFFFFFFFC.
- Bypass and r0: MEM_WB write r3=0xDEADBEEF in the same cycle as sw 0xAC030004 -> readdat2=0xDEADBEEF. A write to r0 of 0x5 -> later read of r0 returns 0.
- Flush: beq 0x10220002 with `EX_MEM_PCSrc`=1 -> wb, m, ex all 0, sign_ext=0x2, and a concurrent write to r4 still commits.
- Unknown opcode 0x3F -> all control outputs 0.
